// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file slave.
package spi_regfile_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        WAIT_CS = 2'd3
    } state_e;

    // Value of the leading R/W bit that marks a write frame
    localparam logic RW_WRITE = 1'b1;

    // Total frame length: R/W bit, address field, data field
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_sync_edge.sv
// N-flop input synchroniser with edge detection on the synchronised level.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    // Shift the asynchronous input through the chain and keep one older sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = chain_q[STAGES-1] & ~prev_q;
    assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 slave with read/write access to a bank of configuration registers.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int               NUM_REGS    = 8,
    parameter int               DATA_W      = 8,
    parameter int               ADDR_W      = 7,
    parameter int               SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       sdi,
    output logic                       sdo,
    output logic                       sdo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FW    = frame_w(ADDR_W, DATA_W);
    localparam int CMD_W = 1 + ADDR_W;
    localparam int CNT_W = $clog2(FW + 1);

    logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
    logic cs_sync_s, cs_rise_s, cs_fall_s;
    logic sdi_sync_s, sdi_rise_s, sdi_fall_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .sync_o(sclk_sync_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(cs_n),
        .sync_o(cs_sync_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .d_i(sdi),
        .sync_o(sdi_sync_s), .rise_o(sdi_rise_s), .fall_o(sdi_fall_s)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CMD_W-1:0]    cmd_sr_q, cmd_sr_d;
    logic [DATA_W-1:0]   wr_sr_q, wr_sr_d;
    logic [DATA_W-1:0]   rd_sr_q, rd_sr_d;
    logic [DATA_W-1:0]   rd_word_s;
    logic                ovr_q, ovr_d;
    logic                sdo_q, sdo_d;
    logic                sdo_oe_q, sdo_oe_d;
    logic                eval_q, eval_d;
    logic                ok_q, ok_d;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_pulse_q, wr_pulse_d;
    logic                frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   addr_s;
    logic                in_range_s;

    // Frame sequencing: next state, shift registers, counter and sdo drive
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sr_d  = cmd_sr_q;
        wr_sr_d   = wr_sr_q;
        rd_sr_d   = rd_sr_q;
        ovr_d     = ovr_q;
        sdo_d     = sdo_q;
        sdo_oe_d  = sdo_oe_q;
        eval_d    = 1'b0;
        ok_d      = 1'b0;
        rd_word_s = '0;
        if (state_q != IDLE && cs_rise_s) begin
            // cs_n rise ends the frame and wins over any coincident sclk edge
            state_d  = IDLE;
            sdo_d    = 1'b0;
            sdo_oe_d = 1'b0;
            eval_d   = 1'b1;
            ok_d     = (state_q == WAIT_CS) && !ovr_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        ovr_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CMD: begin
                    if (sclk_rise_s) begin
                        cmd_sr_d = {cmd_sr_q[CMD_W-2:0], sdi_sync_s};
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(CMD_W)) begin
                            state_d = DATA;
                            if (cmd_sr_d[CMD_W-1] != RW_WRITE) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (32'(cmd_sr_d[ADDR_W-1:0]) == 32'(i)) begin
                                        rd_word_s = regs_q[i];
                                    end else begin
                                        rd_word_s = rd_word_s;
                                    end
                                end
                                rd_sr_d  = rd_word_s;
                                sdo_d    = rd_word_s[DATA_W-1];
                                sdo_oe_d = 1'b1;
                            end else begin
                                sdo_oe_d = 1'b0;
                            end
                        end else begin
                            state_d = CMD;
                        end
                    end else begin
                        state_d = CMD;
                    end
                end
                DATA: begin
                    if (sclk_rise_s) begin
                        wr_sr_d = {wr_sr_q[DATA_W-2:0], sdi_sync_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(FW)) begin
                            state_d = WAIT_CS;
                        end else begin
                            state_d = DATA;
                        end
                    end else if (sclk_fall_s && cnt_q != CNT_W'(CMD_W)) begin
                        // The fall right after the last address bit precedes the
                        // host sampling the MSB, so it must not shift
                        rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
                        sdo_d   = sdo_oe_q & rd_sr_d[DATA_W-1];
                    end else begin
                        state_d = DATA;
                    end
                end
                WAIT_CS: begin
                    if (sclk_rise_s) begin
                        ovr_d = 1'b1;
                    end else begin
                        ovr_d = ovr_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Frame sequencing state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_sr_q <= '0;
            wr_sr_q  <= '0;
            rd_sr_q  <= '0;
            ovr_q    <= 1'b0;
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
            eval_q   <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_sr_q <= cmd_sr_d;
            wr_sr_q  <= wr_sr_d;
            rd_sr_q  <= rd_sr_d;
            ovr_q    <= ovr_d;
            sdo_q    <= sdo_d;
            sdo_oe_q <= sdo_oe_d;
            eval_q   <= eval_d;
            ok_q     <= ok_d;
        end
    end

    assign addr_s     = cmd_sr_q[ADDR_W-1:0];
    assign in_range_s = 32'(addr_s) < 32'(NUM_REGS);

    // Commit a completed write or flag a discarded frame one cycle after cs_n rise
    always_comb begin
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        if (eval_q) begin
            if (ok_q && in_range_s) begin
                if (cmd_sr_q[CMD_W-1] == RW_WRITE) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (32'(addr_s) == 32'(i)) begin
                            regs_d[i] = wr_sr_q;
                        end else begin
                            regs_d[i] = regs_q[i];
                        end
                    end
                    wr_pulse_d = 1'b1;
                    wr_addr_d  = addr_s;
                end else begin
                    wr_pulse_d = 1'b0;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end else begin
            frame_err_d = 1'b0;
        end
    end

    // Register bank and write/error reporting outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wr_pulse_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench: default instance (8x8, ADDR_W 7) and a 4x16, ADDR_W 2, 3-stage instance
// share the SPI pins; each frame is checked against hand-computed values.
module tb_spi_regfile;
    import spi_regfile_pkg::*;

    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        sdi = 1'b0;

    logic        sdo_a, sdo_oe_a, wr_pulse_a, frame_err_a;
    logic [63:0] regs_a;
    logic [6:0]  wr_addr_a;
    logic        sdo_b, sdo_oe_b, wr_pulse_b, frame_err_b;
    logic [63:0] regs_b;
    logic [1:0]  wr_addr_b;

    int tests = 0;
    int failed = 0;
    int wp_a = 0, fe_a = 0, wp_b = 0, fe_b = 0;
    int wp_a0, fe_a0, wp_b0;
    logic [31:0] miso_a, miso_b, oe_a, oe_b;

    spi_regfile dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo_a), .sdo_oe(sdo_oe_a), .regs_o(regs_a),
        .wr_pulse(wr_pulse_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a)
    );

    spi_regfile #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(2), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo_b), .sdo_oe(sdo_oe_b), .regs_o(regs_b),
        .wr_pulse(wr_pulse_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b)
    );

    always #5 clk = ~clk;

    // Count clock cycles during which each pulse output is high
    always @(posedge clk) begin
        if (wr_pulse_a)  wp_a <= wp_a + 1;
        if (frame_err_a) fe_a <= fe_a + 1;
        if (wr_pulse_b)  wp_b <= wp_b + 1;
        if (frame_err_b) fe_b <= fe_b + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Host side of one frame: n bits MSB first, sdo/sdo_oe sampled on each sclk rise
    task automatic spi_frame(input logic [31:0] bits, input int n, input int gap);
        miso_a = '0; miso_b = '0; oe_a = '0; oe_b = '0;
        cs_n = 1'b0;
        #(HALF);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = bits[i];
            #(HALF);
            sclk = 1'b1;
            miso_a = {miso_a[30:0], sdo_a};
            miso_b = {miso_b[30:0], sdo_b};
            oe_a   = {oe_a[30:0], sdo_oe_a};
            oe_b   = {oe_b[30:0], sdo_oe_b};
            #(HALF);
            sclk = 1'b0;
        end
        #(HALF);
        cs_n = 1'b1;
        sdi  = 1'b0;
        #(gap);
    endtask

    task automatic snap();
        wp_a0 = wp_a; fe_a0 = fe_a; wp_b0 = wp_b;
    endtask

    initial begin
        // Reset state
        #100;
        check("rst_regs_a", regs_a, 64'h0);
        check("rst_regs_b", regs_b, 64'h0);
        check("rst_oe_a", {63'h0, sdo_oe_a}, 64'h0);
        check("rst_sdo_a", {63'h0, sdo_a}, 64'h0);
        check("rst_waddr_a", {57'h0, wr_addr_a}, 64'h0);
        check("rst_state_a", {62'h0, dut_a.state_q}, {62'h0, IDLE});
        rst = 1'b0;
        #100;

        // Load reg2 = 0x5A, then reset in the middle of the next frame
        spi_frame(32'h825A, 16, 300);
        check("pre_reg2", regs_a, 64'h0000_0000_005A_0000);
        cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < 5; i++) begin
            sdi = 1'b1;
            #(HALF); sclk = 1'b1;
            #(HALF); sclk = 1'b0;
        end
        rst = 1'b1;
        #20;
        check("midrst_regs_a", regs_a, 64'h0);
        check("midrst_oe_a", {63'h0, sdo_oe_a}, 64'h0);
        check("midrst_state_a", {62'h0, dut_a.state_q}, {62'h0, IDLE});
        cs_n = 1'b1; sdi = 1'b0;
        #100;
        rst = 1'b0;
        #100;

        // Write W addr3 0xA5
        snap();
        spi_frame(32'h83A5, 16, 300);
        check("wr_regs", regs_a, 64'h0000_0000_A500_0000);
        check("wr_pulse_cnt", 64'(wp_a - wp_a0), 64'd1);
        check("wr_ferr_cnt", 64'(fe_a - fe_a0), 64'd0);
        check("wr_addr", {57'h0, wr_addr_a}, 64'd3);
        check("wr_pulse_low", {63'h0, wr_pulse_a}, 64'h0);

        // Read back addr3
        snap();
        spi_frame(32'h0300, 16, 300);
        check("rd_data", {56'h0, miso_a[7:0]}, 64'hA5);
        check("rd_oe", {48'h0, oe_a[15:0]}, 64'h00FF);
        check("rd_regs", regs_a, 64'h0000_0000_A500_0000);
        check("rd_pulse_cnt", 64'(wp_a - wp_a0), 64'd0);
        check("rd_ferr_cnt", 64'(fe_a - fe_a0), 64'd0);
        check("rd_oe_after", {62'h0, sdo_oe_a, sdo_a}, 64'h0);

        // Out-of-range write (addr 10)
        snap();
        spi_frame(32'h8A11, 16, 300);
        check("oor_ferr", 64'(fe_a - fe_a0), 64'd1);
        check("oor_pulse", 64'(wp_a - wp_a0), 64'd0);
        check("oor_regs", regs_a, 64'h0000_0000_A500_0000);

        // Short 15-bit frame
        snap();
        spi_frame(32'h41D2, 15, 300);
        check("short_ferr", 64'(fe_a - fe_a0), 64'd1);
        check("short_regs", regs_a, 64'h0000_0000_A500_0000);

        // 17-bit frame whose first 16 bits would write reg3 = 0x66
        snap();
        spi_frame(32'h106CC, 17, 300);
        check("long_ferr", 64'(fe_a - fe_a0), 64'd1);
        check("long_pulse", 64'(wp_a - wp_a0), 64'd0);
        check("long_regs", regs_a, 64'h0000_0000_A500_0000);

        // Back-to-back writes with one sclk period of cs_n high between them
        snap();
        spi_frame(32'h8011, 16, 2 * HALF);
        spi_frame(32'h8722, 16, 300);
        check("b2b_regs", regs_a, 64'h2200_0000_A500_0011);
        check("b2b_pulses", 64'(wp_a - wp_a0), 64'd2);
        check("b2b_addr", {57'h0, wr_addr_a}, 64'd7);

        // Out-of-range read (addr 10)
        snap();
        spi_frame(32'h0A00, 16, 300);
        check("oor_rd_ferr", 64'(fe_a - fe_a0), 64'd1);
        check("oor_rd_regs", regs_a, 64'h2200_0000_A500_0011);

        // Wide instance: 19-bit write W addr1 0xBEEF, then read it back
        snap();
        spi_frame(32'h5BEEF, 19, 300);
        check("p_wr_regs", regs_b, 64'h0000_0000_BEEF_0000);
        check("p_wr_pulse", 64'(wp_b - wp_b0), 64'd1);
        check("p_wr_addr", {62'h0, wr_addr_b}, 64'd1);
        spi_frame(32'h10000, 19, 300);
        check("p_rd_data", {48'h0, miso_b[15:0]}, 64'hBEEF);
        check("p_rd_oe", {45'h0, oe_b[18:0]}, 64'h0FFFF);
        check("p_rd_regs", regs_b, 64'h0000_0000_BEEF_0000);
        check("a_after_p", regs_a, 64'h2200_0000_A500_0011);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
